// File: rtl/shift_fifo.sv
// Show-ahead FIFO that absorbs the unstallable output of a delay line and raises almost-full early.
// Define SHIFT_FIFO_STATUS_EN to build the level and sticky overflow status ports.
module shift_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int SLACK = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_afull,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data
`ifdef SHIFT_FIFO_STATUS_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] CntFull  = CW'(DEPTH);
  localparam logic [CW-1:0] AfullLvl = CW'(DEPTH - SLACK);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_cnt;
  logic             r_afull;

  logic             w_pop;
  logic             w_push;
  logic [CW-1:0]    w_cntNext;

  assign out_valid = (r_cnt != '0);
  assign w_pop     = out_valid & out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the incoming word.
  assign w_push    = in_valid & ((r_cnt < CntFull) | w_pop);
  assign out_data  = r_mem[r_rdPtr];
  assign in_afull  = r_afull;

  always_comb begin
    w_cntNext = r_cnt;
    if (w_push && !w_pop) begin
      w_cntNext = r_cnt + CW'(1);
    end else if (!w_push && w_pop) begin
      w_cntNext = r_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= in_data;
    end
  end

  // Almost-full is registered from the next count so it tracks the occupancy seen after the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_cnt   <= '0;
      r_afull <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      r_cnt   <= w_cntNext;
      r_afull <= (w_cntNext >= AfullLvl);
    end
  end

`ifdef SHIFT_FIFO_STATUS_EN
  logic w_drop;
  logic r_overflow;

  assign w_drop   = in_valid & ~w_push;
  assign level    = r_cnt;
  assign overflow = r_overflow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_fifo.sv
// Directed self-checking bench for shift_fifo (DEPTH=8, SLACK=4); status ports checked when
// SHIFT_FIFO_STATUS_EN is defined.
module tb_shift_fifo;

  localparam int W = 8;
  localparam int D = 8;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_afull;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef SHIFT_FIFO_STATUS_EN
  logic [3:0]   level;
  logic         overflow;
`endif

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  shift_fifo #(.WIDTH(W), .DEPTH(D), .SLACK(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_afull  (in_afull),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SHIFT_FIFO_STATUS_EN
    ,
    .level     (level),
    .overflow  (overflow)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b1;
    step();
    step();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    assertCount++;
    if (out_valid !== 1'b0) begin
      failCount++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    assertCount++;
    if (in_afull !== 1'b0) begin
      failCount++; $display("[TB] FAIL reset_in_afull: got %b expected 0", in_afull);
    end
`ifdef SHIFT_FIFO_STATUS_EN
    assertCount++;
    if (level !== 4'd0) begin
      failCount++; $display("[TB] FAIL reset_level: got %0d expected 0", level);
    end
    assertCount++;
    if (overflow !== 1'b0) begin
      failCount++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow);
    end
`endif
    step();
    assertCount++;
    if (out_valid !== 1'b0) begin
      failCount++; $display("[TB] FAIL reset_discard: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_fill_drain();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      step();
      assertCount++;
      if (in_afull !== (i >= 4)) begin
        failCount++; $display("[TB] FAIL fill_afull[%0d]: got %b expected %b", i, in_afull, (i >= 4));
      end
`ifdef SHIFT_FIFO_STATUS_EN
      assertCount++;
      if (level !== 4'(i)) begin
        failCount++; $display("[TB] FAIL fill_level[%0d]: got %0d expected %0d", i, level, i);
      end
`endif
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      assertCount++;
      if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
        failCount++;
        $display("[TB] FAIL drain_data[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, out_data, 8'(i));
      end
      assertCount++;
      if (in_afull !== ((9 - i) >= 4)) begin
        failCount++; $display("[TB] FAIL drain_afull[%0d]: got %b expected %b", i, in_afull, ((9 - i) >= 4));
      end
      step();
    end
    out_ready = 1'b0;
    assertCount++;
    if (out_valid !== 1'b0 || in_afull !== 1'b0) begin
      failCount++; $display("[TB] FAIL drain_empty: got valid=%b afull=%b expected 0 0", out_valid, in_afull);
    end
  endtask

  task automatic test_full_push_pop();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      step();
    end
    in_valid = 1'b1; in_data = 8'h09; out_ready = 1'b1;
    assertCount++;
    if (out_data !== 8'h01) begin
      failCount++; $display("[TB] FAIL fullpp_head: got %h expected 01", out_data);
    end
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    assertCount++;
    if (out_data !== 8'h02 || in_afull !== 1'b1) begin
      failCount++; $display("[TB] FAIL fullpp_next: got data=%h afull=%b expected 02 1", out_data, in_afull);
    end
`ifdef SHIFT_FIFO_STATUS_EN
    assertCount++;
    if (level !== 4'd8 || overflow !== 1'b0) begin
      failCount++; $display("[TB] FAIL fullpp_status: got level=%0d ovf=%b expected 8 0", level, overflow);
    end
`endif
    out_ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      assertCount++;
      if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
        failCount++;
        $display("[TB] FAIL fullpp_drain[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, out_data, 8'(i));
      end
      step();
    end
    out_ready = 1'b0;
    assertCount++;
    if (out_valid !== 1'b0) begin
      failCount++; $display("[TB] FAIL fullpp_empty: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h10 + i);
      step();
    end
    in_valid = 1'b1; in_data = 8'hAA;
    step();
    in_valid = 1'b0;
    assertCount++;
    if (out_valid !== 1'b1 || in_afull !== 1'b1) begin
      failCount++; $display("[TB] FAIL ovf_full: got valid=%b afull=%b expected 1 1", out_valid, in_afull);
    end
`ifdef SHIFT_FIFO_STATUS_EN
    assertCount++;
    if (overflow !== 1'b1 || level !== 4'd8) begin
      failCount++; $display("[TB] FAIL ovf_flag: got ovf=%b level=%0d expected 1 8", overflow, level);
    end
`endif
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      assertCount++;
      if (out_valid !== 1'b1 || out_data !== 8'(8'h10 + i)) begin
        failCount++;
        $display("[TB] FAIL ovf_drain[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, out_valid, out_data, 8'(8'h10 + i));
      end
      step();
    end
    out_ready = 1'b0;
    assertCount++;
    if (out_valid !== 1'b0) begin
      failCount++; $display("[TB] FAIL ovf_no_aa: got valid=%b data=%h expected valid=0", out_valid, out_data);
    end
`ifdef SHIFT_FIFO_STATUS_EN
    assertCount++;
    if (overflow !== 1'b1) begin
      failCount++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow);
    end
`endif
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h40 + i);
      step();
    end
    in_valid = 1'b0;
    assertCount++;
    if (out_valid !== 1'b1 || in_afull !== 1'b1) begin
      failCount++; $display("[TB] FAIL midrst_pre: got valid=%b afull=%b expected 1 1", out_valid, in_afull);
    end
`ifdef SHIFT_FIFO_STATUS_EN
    assertCount++;
    if (level !== 4'd5) begin
      failCount++; $display("[TB] FAIL midrst_pre_level: got %0d expected 5", level);
    end
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    assertCount++;
    if (out_valid !== 1'b0 || in_afull !== 1'b0) begin
      failCount++; $display("[TB] FAIL midrst_post: got valid=%b afull=%b expected 0 0", out_valid, in_afull);
    end
`ifdef SHIFT_FIFO_STATUS_EN
    assertCount++;
    if (level !== 4'd0 || overflow !== 1'b0) begin
      failCount++; $display("[TB] FAIL midrst_status: got level=%0d ovf=%b expected 0 0", level, overflow);
    end
`endif
    in_valid = 1'b1; in_data = 8'h33;
    step();
    in_valid = 1'b0;
    assertCount++;
    if (out_valid !== 1'b1 || out_data !== 8'h33) begin
      failCount++; $display("[TB] FAIL midrst_first: got valid=%b data=%h expected 1 33", out_valid, out_data);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    assertCount++;
    if (out_valid !== 1'b0) begin
      failCount++; $display("[TB] FAIL midrst_empty: got %b expected 0", out_valid);
    end
  endtask

  // Source halts on in_afull, but its words pass through a 4-deep delay before reaching the FIFO.
  task automatic test_streaming();
    logic         pipeV [4];
    logic [W-1:0] pipeD [4];
    int sent = 0;
    int rx = 0;
    int cycles = 0;
    for (int j = 0; j < 4; j++) begin
      pipeV[j] = 1'b0; pipeD[j] = '0;
    end
    while (rx < 100 && cycles < 3000) begin
      for (int j = 3; j > 0; j--) begin
        pipeV[j] = pipeV[j-1]; pipeD[j] = pipeD[j-1];
      end
      if (sent < 100 && !in_afull) begin
        pipeV[0] = 1'b1; pipeD[0] = 8'(sent * 7 + 3); sent++;
      end else begin
        pipeV[0] = 1'b0;
      end
      in_valid  = pipeV[3];
      in_data   = pipeD[3];
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        assertCount++;
        if (out_data !== 8'(rx * 7 + 3)) begin
          failCount++; $display("[TB] FAIL stream_data[%0d]: got %h expected %h", rx, out_data, 8'(rx * 7 + 3));
        end
        rx++;
      end
      step();
      cycles++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    assertCount++;
    if (rx !== 100) begin
      failCount++; $display("[TB] FAIL stream_count: got %0d words expected 100 (cycles %0d)", rx, cycles);
    end
    assertCount++;
    if (out_valid !== 1'b0) begin
      failCount++; $display("[TB] FAIL stream_empty: got %b expected 0", out_valid);
    end
`ifdef SHIFT_FIFO_STATUS_EN
    assertCount++;
    if (overflow !== 1'b0) begin
      failCount++; $display("[TB] FAIL stream_no_drop: got %b expected 0", overflow);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_fill_drain();
    test_full_push_pop();
    test_overflow();
    test_mid_reset();
    test_streaming();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
